rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
Round-robin arbiter for the shared serial bus. It takes up to 12 master request lines and issues one-hot grants. It uses the open-drain, active-low bus_util line to track whether the granted master has taken the bus and released it. It revokes stale grants with an acknowledge timeout, and exports the current master ID, FSM state and utilisation/timeout statistics to the top-level displays and LEDs.

Parameters:
NUM_MASTERS, 12, number of request/grant lines (max 16).
ACK_TIMEOUT, 16, cycles allowed in GRANT for bus_util to go low.
STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
clk  input  1  system clock.
rstn  input  1  asynchronous active-low reset.
m_reqs  input  NUM_MASTERS  request per master, level, held until done.
bus_util  input  1  bus utilising line, active-low (0 = master driving the bus).
m_grants  output  NUM_MASTERS  one-hot grant, registered.
mid_current  output  4  index of the most recently granted master.
state  output  4  FSM state code, for hex display.
bus_busy  output  1  high while in BUSY.
timeout_err  output  1  one-cycle pulse on an acknowledge timeout.
util_cycles  output  STAT_WIDTH  count of BUSY cycles, saturating.
timeout_cnt  output  STAT_WIDTH  count of timeouts, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - m_grants = 0, mid_current = 0, state = IDLE (0), bus_busy = 0, timeout_err = 0.
  - util_cycles = 0, timeout_cnt = 0.
  - Internal last-grant pointer = NUM_MASTERS-1, so master 0 wins first.
  - Acknowledge counter = 0.
- State codes: IDLE = 0, GRANT = 1, BUSY = 2, RELEASE = 3. Codes 4-15 are unused; an illegal state returns to IDLE with grants cleared.
- IDLE:
  - If any m_reqs bit is set, select the first requester searching from (last+1) mod NUM_MASTERS upward, with wrap.
  - Next cycle: the winner's grant bit is set, mid_current = winner, last = winner, acknowledge counter cleared, state -> GRANT.
  - Latency from request to grant is 1 cycle.
  - With no request, stay in IDLE with grants at 0.
- GRANT (grant held):
  - If bus_util == 0: -> BUSY (takes priority over the other conditions in the same cycle).
  - Else if the granted master's request = 0 (withdrawn): -> RELEASE.
  - Else if counter == ACK_TIMEOUT-1: timeout_err = 1 for one cycle, timeout_cnt += 1 (saturating), -> RELEASE.
  - Else counter += 1.
- BUSY:
  - Grant held, bus_busy = 1, util_cycles += 1 per cycle (saturating at all ones).
  - Dropping the request while bus_util is still 0 does not leave BUSY.
  - When bus_util == 1: -> RELEASE.
- RELEASE: m_grants = 0 and bus_busy = 0 for exactly one cycle, then -> IDLE. This is the guaranteed dead cycle between owners. Requests seen here are evaluated in IDLE.
- Grant integrity: at most one m_grants bit is set at any time. The grant never changes owner without passing through RELEASE.
- Fairness: a master that just finished is lowest priority next round. Every continuously requesting master is granted within NUM_MASTERS arbitration rounds.
- Input bounds: request bits at or above NUM_MASTERS do not exist. mid_current is zero-extended to 4 bits.
- bus_util outside an owner: bus_util is ignored in IDLE and RELEASE. Stray low pulses there do not affect the FSM or the counters.
- Reset mid-transaction: grants and bus_busy drop immediately (asynchronously), and all counters and the pointer return to their reset values.

Test Plan:
- Reset then m_reqs = 12'h004 -> m_grants = 12'h004 one cycle later, mid_current = 2, state = 1. Drive bus_util = 0 -> state 2, bus_busy = 1. Hold for 5 cycles, then bus_util = 1 -> util_cycles = 5, one RELEASE cycle with grants = 0, back to IDLE.
- m_reqs = 12'h034 held continuously, each owner using the bus for 3 cycles -> grant order 2, 4, 5, 2, 4. A RELEASE gap appears between every pair of owners.
- m_reqs = 12'h010, bus_util kept high -> timeout_err pulses on the 16th GRANT cycle, timeout_cnt = 1, grant drops, IDLE. The request is still high, so master 4 is re-granted next.
- Granted master drops its request in GRANT before bus_util goes low -> RELEASE with no timeout, timeout_cnt unchanged.
- rstn asserted low during BUSY -> m_grants = 0, state = 0, util_cycles = 0 with no clock edge. After release, the first grant goes to the lowest requesting index.
- Force util_cycles to 16'hFFFE, then 3 BUSY cycles -> util_cycles holds at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin shared-bus arbiter with ack timeout and usage statistics
module rr_bus_arbiter #(
    parameter int NUM_MASTERS = 12,
    parameter int ACK_TIMEOUT = 16,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_reqs,
    input  logic                   bus_util,
    output logic [NUM_MASTERS-1:0] m_grants,
    output logic [3:0]             mid_current,
    output logic [3:0]             state,
    output logic                   bus_busy,
    output logic                   timeout_err,
    output logic [STAT_WIDTH-1:0]  util_cycles,
    output logic [STAT_WIDTH-1:0]  timeout_cnt
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        GRANT   = 4'd1,
        BUSY    = 4'd2,
        RELEASE = 4'd3
    } state_t;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0]          ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grants_d;
    logic [3:0]             mid_d, last_q, last_d;
    logic [CW-1:0]          ack_q, ack_d;
    logic [STAT_WIDTH-1:0]  util_d, tocnt_d;
    logic [NUM_MASTERS-1:0] above_last, upper_reqs, pick_reqs, win_onehot;
    logic [3:0]             win_idx;
    logic                   granted_req;

    // Requesters above the last winner go first; otherwise wrap to the lowest requester.
    assign above_last  = ~(((ONE << 1) << last_q) - ONE);
    assign upper_reqs  = m_reqs & above_last;
    assign pick_reqs   = (upper_reqs != '0) ? upper_reqs : m_reqs;
    assign win_onehot  = pick_reqs & (~pick_reqs + ONE);
    assign win_idx     = 4'($countones(win_onehot - ONE));
    assign granted_req = |(m_reqs & m_grants);

    assign state    = state_q;
    assign bus_busy = (state_q == BUSY);

    always_comb begin
        state_d     = state_q;
        grants_d    = m_grants;
        mid_d       = mid_current;
        last_d      = last_q;
        ack_d       = ack_q;
        util_d      = util_cycles;
        tocnt_d     = timeout_cnt;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                grants_d = '0;
                if (m_reqs != '0) begin
                    state_d  = GRANT;
                    grants_d = win_onehot;
                    mid_d    = win_idx;
                    last_d   = win_idx;
                    ack_d    = '0;
                end
            end
            GRANT: begin
                // Bus take-up wins over withdrawal and timeout in the same cycle.
                if (!bus_util) begin
                    state_d = BUSY;
                end else if (!granted_req) begin
                    state_d  = RELEASE;
                    grants_d = '0;
                end else if (ack_q == ACK_LAST) begin
                    timeout_err = 1'b1;
                    if (timeout_cnt != '1) tocnt_d = timeout_cnt + 1'b1;
                    state_d  = RELEASE;
                    grants_d = '0;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            BUSY: begin
                if (util_cycles != '1) util_d = util_cycles + 1'b1;
                if (bus_util) begin
                    state_d  = RELEASE;
                    grants_d = '0;
                end
            end
            RELEASE: begin
                state_d  = IDLE;
                grants_d = '0;
            end
            default: begin
                state_d  = IDLE;
                grants_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            m_grants    <= '0;
            mid_current <= '0;
            last_q      <= 4'(NUM_MASTERS - 1);
            ack_q       <= '0;
            util_cycles <= '0;
            timeout_cnt <= '0;
        end else begin
            state_q     <= state_d;
            m_grants    <= grants_d;
            mid_current <= mid_d;
            last_q      <= last_d;
            ack_q       <= ack_d;
            util_cycles <= util_d;
            timeout_cnt <= tocnt_d;
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - scoreboard bench for rr_bus_arbiter
module tb_rr_bus_arbiter;
    localparam int N = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  m_reqs;
    logic          bus_util;
    logic [N-1:0]  m_grants;
    logic [3:0]    mid_current, state;
    logic          bus_busy, timeout_err;
    logic [15:0]   util_cycles, timeout_cnt;

    logic [3:0]    m_reqs2, m_grants2, mid2, state2, util2, to2;
    logic          bus_util2, busy2, terr2;

    always #5 clk = ~clk;

    rr_bus_arbiter dut (
        .clk(clk), .rstn(rstn), .m_reqs(m_reqs), .bus_util(bus_util),
        .m_grants(m_grants), .mid_current(mid_current), .state(state),
        .bus_busy(bus_busy), .timeout_err(timeout_err),
        .util_cycles(util_cycles), .timeout_cnt(timeout_cnt)
    );

    rr_bus_arbiter #(.NUM_MASTERS(4), .ACK_TIMEOUT(2), .STAT_WIDTH(4)) dut2 (
        .clk(clk), .rstn(rstn), .m_reqs(m_reqs2), .bus_util(bus_util2),
        .m_grants(m_grants2), .mid_current(mid2), .state(state2),
        .bus_busy(busy2), .timeout_err(terr2),
        .util_cycles(util2), .timeout_cnt(to2)
    );

    typedef struct {
        int winner;
        int kind;
        int exp_util;
        int exp_to;
    } sb_item_t;

    sb_item_t     sb_q[$];
    sb_item_t     cur;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0, have_cur = 1'b0, at_release = 1'b0, abort = 1'b0;
    int           last_m, util_m, to_m, age;
    logic [N-1:0] req_v, prev_grants;
    logic [3:0]   prev_state;

    task automatic chk(input string name, input logic ok, input longint act, input longint exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            int idx = (last + off) % N;
            if (((r >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("grant_onehot", $countones(m_grants) <= 1, $countones(m_grants), 1);
            if (state == 4'd2) chk("busy_flag", bus_busy == 1'b1 && m_grants != '0, bus_busy, 1);
            if (state == 4'd0 || state == 4'd3)
                chk("idle_no_grant", m_grants == '0 && !bus_busy, m_grants, 0);
            if (prev_state == 4'd3) chk("release_one_cycle", state == 4'd0, state, 0);
            if (m_grants != '0 && prev_grants != '0)
                chk("owner_stable", m_grants == prev_grants, m_grants, prev_grants);
            if (m_grants != '0 && prev_grants == '0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_grant", 1'b0, m_grants, 0);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1'b1;
                    age = 0;
                    chk("grant_vec", m_grants == (N'(1) << cur.winner), m_grants, N'(1) << cur.winner);
                    chk("mid_current", mid_current == 4'(cur.winner), mid_current, cur.winner);
                end
            end
            if (state == 4'd1) age++;
            if (timeout_err)
                chk("timeout_pulse", have_cur && cur.kind == 2 && age == 16 && state == 4'd1, age, 16);
            if (have_cur && (state == 4'd3 || (state == 4'd0 && !bus_util))) begin
                chk("util_cycles", util_cycles == 16'(cur.exp_util), util_cycles, cur.exp_util);
                chk("timeout_cnt", timeout_cnt == 16'(cur.exp_to), timeout_cnt, cur.exp_to);
            end
        end
        prev_grants = m_grants;
        prev_state  = state;
    end

    task automatic do_reset();
        rstn = 1'b0; m_reqs = '0; bus_util = 1'b1; req_v = '0;
        m_reqs2 = '0; bus_util2 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b1;
        last_m = N - 1; util_m = 0; to_m = 0; have_cur = 1'b0; at_release = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic go_idle();
        req_v = '0; m_reqs = '0; bus_util = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        at_release = 1'b0;
    endtask

    task automatic idle_phase();
        m_reqs = '0;
        repeat ($urandom_range(2, 5)) begin
            bus_util = 1'($urandom);
            @(posedge clk); #1;
        end
        bus_util = 1'b1;
        at_release = 1'b0;
    endtask

    // kind 0: bus used for k cycles after d GRANT cycles; 1: withdraw after d cycles; 2: no ack (timeout)
    task automatic do_txn(input int kind, input int d, input int k, input bit keep);
        int w, n;
        sb_item_t it;
        if (req_v == '0) return;
        bus_util = 1'b1;
        w = rr_pick(req_v, last_m);
        last_m = w;
        if (kind == 0) util_m += k;
        else if (kind == 2) to_m += 1;
        it.winner = w; it.kind = kind; it.exp_util = util_m; it.exp_to = to_m;
        sb_q.push_back(it);
        m_reqs = req_v;
        n = 0;
        while (m_grants == '0 && n < 4) begin @(posedge clk); #1; n++; end
        chk("grant_latency", n == (at_release ? 2 : 1), n, at_release ? 2 : 1);
        if (m_grants == '0) begin abort = 1'b1; return; end
        case (kind)
            0: begin
                repeat (d) begin @(posedge clk); #1; end
                bus_util = 1'b0;
                for (int i = 0; i < k; i++) begin
                    @(posedge clk); #1;
                    if (i == 0 && !keep) begin req_v &= ~(N'(1) << w); m_reqs = req_v; end
                end
                bus_util = 1'b1;
            end
            1: begin
                repeat (d) begin @(posedge clk); #1; end
                req_v &= ~(N'(1) << w);
                m_reqs = req_v;
            end
            default: ;
        endcase
        n = 0;
        while (state != 4'd3 && n < 40) begin @(posedge clk); #1; n++; end
        chk("reach_release", state == 4'd3, state, 3);
        if (state != 4'd3) abort = 1'b1;
        if (kind == 2 && !keep) begin req_v &= ~(N'(1) << w); m_reqs = req_v; end
        at_release = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; m_reqs = '0; bus_util = 1'b1; m_reqs2 = '0; bus_util2 = 1'b1; req_v = '0;
        #2;
        chk("rst_grants", m_grants == '0, m_grants, 0);
        chk("rst_mid", mid_current == 4'd0, mid_current, 0);
        chk("rst_state", state == 4'd0, state, 0);
        chk("rst_busy", bus_busy == 1'b0, bus_busy, 0);
        chk("rst_terr", timeout_err == 1'b0, timeout_err, 0);
        chk("rst_util", util_cycles == 16'd0, util_cycles, 0);
        chk("rst_tocnt", timeout_cnt == 16'd0, timeout_cnt, 0);
        do_reset();
        mon_en = 1'b1;

        req_v = 12'h004; do_txn(0, 0, 5, 1'b0);
        go_idle();

        do_reset();
        req_v = 12'h034;
        repeat (5) do_txn(0, 0, 3, 1'b1);
        go_idle();

        req_v = 12'h010;
        do_txn(2, 0, 0, 1'b1);
        do_txn(1, 3, 0, 1'b0);
        go_idle();

        // Asynchronous reset in the middle of a bus tenure.
        mon_en = 1'b0;
        m_reqs = 12'h0A0;
        @(posedge clk); #1;
        chk("pre_rst_grant", m_grants == 12'h020, m_grants, 12'h020);
        bus_util = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_busy", state == 4'd2, state, 2);
        #2 rstn = 1'b0;
        #1;
        chk("async_grants", m_grants == '0, m_grants, 0);
        chk("async_state", state == 4'd0, state, 0);
        chk("async_util", util_cycles == 16'd0, util_cycles, 0);
        chk("async_busy", bus_busy == 1'b0, bus_busy, 0);
        rstn = 1'b1; bus_util = 1'b1; m_reqs = 12'h408;
        @(posedge clk); #1;
        chk("post_rst_grant", m_grants == 12'h008, m_grants, 12'h008);
        m_reqs = '0;
        repeat (2) begin @(posedge clk); #1; end
        last_m = 3; util_m = 0; to_m = 0; have_cur = 1'b0; at_release = 1'b0; req_v = '0;
        mon_en = 1'b1;

        for (int t = 0; t < 200 && !abort; t++) begin
            int kind_r;
            int kind;
            if (req_v == '0) begin
                idle_phase();
                req_v = N'($urandom_range(1, 4095));
            end
            kind_r = $urandom_range(0, 3);
            kind = (kind_r < 2) ? 0 : kind_r - 1;
            do_txn(kind, $urandom_range(0, 15), $urandom_range(1, 6), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) req_v = '0;
            else req_v |= N'($urandom) & N'($urandom) & N'($urandom);
        end
        go_idle();
        mon_en = 1'b0;

        // Saturation on a narrow-counter instance.
        m_reqs2 = 4'b0001; bus_util2 = 1'b0;
        repeat (25) begin @(posedge clk); #1; end
        chk("sat_busy_state", state2 == 4'd2, state2, 2);
        chk("sat_util", util2 == 4'hF, util2, 15);
        bus_util2 = 1'b1; m_reqs2 = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("sat_util_hold", util2 == 4'hF, util2, 15);
        m_reqs2 = 4'b0100;
        @(posedge clk); #1;
        chk("sat_grant2", m_grants2 == 4'b0100, m_grants2, 4'b0100);
        repeat (10) begin @(posedge clk); #1; end
        chk("timeouts_three", to2 == 4'd3, to2, 3);
        repeat (89) begin @(posedge clk); #1; end
        chk("sat_timeouts", to2 == 4'hF, to2, 15);
        m_reqs2 = '0;

        chk("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
